// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed MULT/DIV engine.
// Holds the FSM state and op encodings, the R-type funct codes the control
// unit decodes, default widths, and two small funct decode helpers.
package mult_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1a;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;

    // True for the functs that launch an operation on this unit.
    function automatic logic funct_starts_op(input logic [5:0] funct);
        return (funct == FN_MULT) || (funct == FN_DIV);
    endfunction

    // True for the functs that read back HI/LO.
    function automatic logic funct_reads_hilo(input logic [5:0] funct);
        return (funct == FN_MFHI) || (funct == FN_MFLO);
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the control unit (master) and the MULT/DIV
// engine (slave).
//   start_mult, start_div : one-cycle requests, sampled with a and b
//   a, b                  : operands
//   busy, done, div_zero  : engine status
//   hi, lo                : result registers
interface mult_div_if #(
    parameter int unsigned WIDTH = mult_div_pkg::DEFAULT_WIDTH
);
    import mult_div_pkg::*;

    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mult, start_div, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on magnitudes.
//   rem_in    : partial remainder, always < divisor
//   bit_in    : next dividend bit shifted in at the bottom
//   divisor   : divisor magnitude
//   rem_out_c : new partial remainder
//   q_bit_c   : quotient bit produced by this step
module div_step #(
    parameter int unsigned WIDTH = mult_div_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out_c,
    output logic             q_bit_c
);
    import mult_div_pkg::*;

    logic [WIDTH:0] shifted;

    // Shifted remainder can reach 2*divisor-1, so compare at WIDTH+1 bits.
    // Either result is < divisor and therefore fits back into WIDTH bits.
    always_comb begin
        shifted   = {rem_in, bit_in};
        q_bit_c   = (shifted >= {1'b0, divisor});
        rem_out_c = q_bit_c ? WIDTH'(shifted - {1'b0, divisor}) : WIDTH'(shifted);
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV engine.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mult_div_if (starts, operands, busy/done,
//                div_zero, hi/lo results)
// MULT is shift-add and DIV is restoring division, both on operand magnitudes
// in a shared 2*WIDTH accumulator, one iteration per RUN cycle. A shared sign
// fix-up stage negates the result on the final RUN edge.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               sign_a_q, sign_a_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand signs and magnitudes at the accepting edge.
    logic               sign_a_c, sign_b_c;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;

    assign sign_a_c = bus.a[WIDTH-1];
    assign sign_b_c = bus.b[WIDTH-1];
    assign mag_a_c  = sign_a_c ? (~bus.a + WIDTH'(1)) : bus.a;
    assign mag_b_c  = sign_b_c ? (~bus.b + WIDTH'(1)) : bus.b;

    // Shift-add step: upper half accumulates the multiplicand, then shift right.
    logic [WIDTH:0]     mult_sum_c;
    logic [ACC_W-1:0]   mult_next_c;

    assign mult_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]}
                       + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mult_next_c = {mult_sum_c, acc_q[WIDTH-1:1]};

    // Restoring step: upper half is the remainder, lower half shifts the
    // dividend out at the top and the quotient in at the bottom.
    logic [WIDTH-1:0]   div_rem_c;
    logic               div_q_bit_c;
    logic [ACC_W-1:0]   div_next_c;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in    (acc_q[ACC_W-1:WIDTH]),
        .bit_in    (acc_q[WIDTH-1]),
        .divisor   (opnd_q),
        .rem_out_c (div_rem_c),
        .q_bit_c   (div_q_bit_c)
    );

    assign div_next_c = {div_rem_c, acc_q[WIDTH-2:0], div_q_bit_c};

    logic [ACC_W-1:0]   step_c;
    assign step_c = (op_q == OP_MULT) ? mult_next_c : div_next_c;

    // Shared sign fix-up. MULT negates the full 2*WIDTH product: the upper
    // half carries in only when the lower half is zero. DIV negates quotient
    // and remainder independently (remainder follows the sign of a).
    logic [WIDTH-1:0]   hi_raw_c, lo_raw_c, hi_fix_c, lo_fix_c;
    logic               neg_hi_c, hi_cin_c;

    assign hi_raw_c = step_c[ACC_W-1:WIDTH];
    assign lo_raw_c = step_c[WIDTH-1:0];
    assign neg_hi_c = (op_q == OP_MULT) ? neg_q : sign_a_q;
    assign hi_cin_c = (op_q == OP_MULT) ? (lo_raw_c == '0) : 1'b1;
    assign lo_fix_c = neg_q    ? (~lo_raw_c + WIDTH'(1))        : lo_raw_c;
    assign hi_fix_c = neg_hi_c ? (~hi_raw_c + WIDTH'(hi_cin_c)) : hi_raw_c;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            neg_q      <= neg_d;
            sign_a_q   <= sign_a_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        neg_d      = neg_q;
        sign_a_d   = sign_a_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start_mult || bus.start_div) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    sign_a_d   = sign_a_c;
                    neg_d      = sign_a_c ^ sign_b_c;
                    // MULT has priority when both starts arrive together.
                    if (bus.start_mult) begin
                        op_d   = OP_MULT;
                        opnd_d = mag_a_c;
                        acc_d  = {{WIDTH{1'b0}}, mag_b_c};
                    end else begin
                        op_d   = OP_DIV;
                        opnd_d = mag_b_c;
                        acc_d  = {{WIDTH{1'b0}}, mag_a_c};
                    end
                end
            end
            RUN: begin
                // A zero divisor leaves after the operand-latch cycle with
                // no iterations and hi/lo untouched.
                if ((op_q == OP_DIV) && (cnt_q == '0) && (opnd_q == '0)) begin
                    state_d    = DONE;
                    div_zero_d = 1'b1;
                end else begin
                    acc_d = step_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        hi_d    = hi_fix_c;
                        lo_d    = lo_fix_c;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of single operations plus
// hand-written sequences for start-while-busy and reset mid-operation.
module tb_mult_div_unit;

    localparam int unsigned W      = 32;
    localparam int          WINDOW = 40;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        bit          sm;
        bit          sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request on the next negedge; it is accepted on the following
    // posedge (E0). Returns at the negedge after E0 with starts cleared.
    task automatic issue(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_mult = sm;
        bus.start_div  = sd;
        bus.a          = a;
        bus.b          = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
    endtask

    // Watch a bounded window after E0: first done edge index and pulse count.
    task automatic watch(output int lat, output int pulses);
        lat    = -1;
        pulses = 0;
        for (int e = 1; e <= WINDOW; e++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = e;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat, pulses;
        issue(v.sm, v.sd, v.a, v.b);
        check({v.name, "/busy_e0"}, 32'(bus.busy), 32'd1);
        check({v.name, "/dz_clear_e0"}, 32'(bus.div_zero), 32'd0);
        watch(lat, pulses);
        check({v.name, "/latency"}, 32'(lat), 32'(v.lat));
        check({v.name, "/pulses"}, 32'(pulses), 32'd1);
        check({v.name, "/hi"}, bus.hi, v.hi);
        check({v.name, "/lo"}, bus.lo, v.lo);
        check({v.name, "/div_zero"}, 32'(bus.div_zero), 32'(v.dz));
        check({v.name, "/busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat, pulses;

        //           name          sm    sd    a             b             hi            lo            dz  lat
        vecs.push_back('{"mul_7_m3",    1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32});
        vecs.push_back('{"div_m7_2",    1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32});
        vecs.push_back('{"div_min_m1",  1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32});
        vecs.push_back('{"mul_m1_m1",   1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 32});
        vecs.push_back('{"both_6_3",    1'b1, 1'b1, 32'd6,        32'd3,        32'h00000000, 32'h00000012, 1'b0, 32});
        vecs.push_back('{"mul_min_min", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32});
        vecs.push_back('{"mul_max_min", 1'b1, 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 32});
        vecs.push_back('{"div_7_m2",    1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32});
        vecs.push_back('{"div_100_7",   1'b0, 1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 32});
        vecs.push_back('{"div_min_2",   1'b0, 1'b1, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 1'b0, 32});
        vecs.push_back('{"div_m100_m7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 32});
        // Zero divisor: hi/lo keep the previous result.
        vecs.push_back('{"div_5_0",     1'b0, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFE, 32'h0000000E, 1'b1, 1});
        vecs.push_back('{"mul_3_5",     1'b1, 1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 1'b0, 32});
        vecs.push_back('{"div_0_5",     1'b0, 1'b1, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0, 32});

        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/done", 32'(bus.done), 32'd0);
        check("rst/div_zero", 32'(bus.div_zero), 32'd0);
        check("rst/hi", bus.hi, 32'd0);
        check("rst/lo", bus.lo, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // hi/lo hold while idle.
        repeat (5) @(negedge clk);
        check("hold/hi", bus.hi, 32'd0);
        check("hold/lo", bus.lo, 32'd0);

        // Start while busy: a DIV-by-zero request mid-MULT must be ignored.
        issue(1'b1, 1'b0, 32'h00010000, 32'h00010000);
        lat    = -1;
        pulses = 0;
        for (int e = 1; e <= WINDOW; e++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = e;
            end
            if (e == 9) begin
                bus.start_div = 1'b1;
                bus.a         = 32'd5;
                bus.b         = 32'd0;
            end else if (e == 10) begin
                bus.start_div = 1'b0;
            end
        end
        check("busy_start/latency", 32'(lat), 32'd32);
        check("busy_start/pulses", 32'(pulses), 32'd1);
        check("busy_start/hi", bus.hi, 32'd1);
        check("busy_start/lo", bus.lo, 32'd0);
        check("busy_start/div_zero", 32'(bus.div_zero), 32'd0);
        check("busy_start/busy_after", 32'(bus.busy), 32'd0);

        // Reset while RUN counter is 15 discards the operation and clears hi/lo.
        issue(1'b1, 1'b0, 32'h00012345, 32'h00006789);
        repeat (15) @(negedge clk);
        check("mid_rst/busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst/busy", 32'(bus.busy), 32'd0);
        check("mid_rst/done", 32'(bus.done), 32'd0);
        check("mid_rst/hi", bus.hi, 32'd0);
        check("mid_rst/lo", bus.lo, 32'd0);
        watch(lat, pulses);
        check("mid_rst/no_done", 32'(pulses), 32'd0);
        run_vec('{"mul_3_4_after_rst", 1'b1, 1'b0, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0, 32});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
